// File: rtl/rx_line_buffer.sv
// 16-cell character line buffer fed by a UART receive strobe. Printable bytes
// append (or scroll), backspace erases, CR blanks the line one cell per cycle.
module rx_line_buffer #(
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter bit         SCROLL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] L0,
  output logic [7:0] L1,
  output logic [7:0] L2,
  output logic [7:0] L3,
  output logic [7:0] L4,
  output logic [7:0] L5,
  output logic [7:0] L6,
  output logic [7:0] L7,
  output logic [7:0] L8,
  output logic [7:0] L9,
  output logic [7:0] L_A,
  output logic [7:0] L_B,
  output logic [7:0] L_C,
  output logic [7:0] L_D,
  output logic [7:0] L_E,
  output logic [7:0] L_F,
  output logic [4:0] char_count,
  output logic       line_full,
  output logic       overrun
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cell [16];
  logic [4:0] r_count;
  logic [3:0] r_idx;
  logic       r_overrun;

  logic       w_accept;
  logic       w_print;
  logic       w_bs;
  logic       w_cr;
  logic       w_full;
  logic       w_overrun;
  logic [4:0] w_cnt_dec;

  assign rx_ready  = (r_state == IDLE);
  assign w_accept  = rx_valid && rx_ready;
  assign w_print   = (rx_data >= 8'h20) && (rx_data <= 8'h7E);
  assign w_bs      = (rx_data == 8'h08) || (rx_data == 8'h7F);
  assign w_cr      = (rx_data == 8'h0D);
  assign w_full    = (r_count == 5'd16);
  assign w_cnt_dec = r_count - 5'd1;

  // Drops: anything offered while busy, or a printable into a full line that may not scroll.
  assign w_overrun = (rx_valid && !rx_ready) ||
                     (w_accept && w_print && w_full && !SCROLL_EN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_cr) w_state_nxt = CLEAR;
      CLEAR:   if (r_idx == 4'd15)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) r_cell[i] <= FILL_CHAR;
      r_count   <= 5'd0;
      r_idx     <= 4'd0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_overrun;
      if (r_state == CLEAR) begin
        // Index wraps 15 -> 0 on its own, leaving it ready for the next CR.
        r_cell[r_idx] <= FILL_CHAR;
        r_idx         <= r_idx + 4'd1;
      end else if (w_accept) begin
        if (w_print) begin
          if (!w_full) begin
            r_cell[r_count[3:0]] <= rx_data;
            r_count              <= r_count + 5'd1;
          end else if (SCROLL_EN) begin
            for (int i = 0; i < 15; i++) r_cell[i] <= r_cell[i+1];
            r_cell[15] <= rx_data;
          end
        end else if (w_bs) begin
          if (r_count != 5'd0) begin
            r_cell[w_cnt_dec[3:0]] <= FILL_CHAR;
            r_count                <= w_cnt_dec;
          end
        end else if (w_cr) begin
          r_count <= 5'd0;
        end
      end
    end
  end

  assign char_count = r_count;
  assign line_full  = w_full;
  assign overrun    = r_overrun;

  assign L0  = r_cell[0];
  assign L1  = r_cell[1];
  assign L2  = r_cell[2];
  assign L3  = r_cell[3];
  assign L4  = r_cell[4];
  assign L5  = r_cell[5];
  assign L6  = r_cell[6];
  assign L7  = r_cell[7];
  assign L8  = r_cell[8];
  assign L9  = r_cell[9];
  assign L_A = r_cell[10];
  assign L_B = r_cell[11];
  assign L_C = r_cell[12];
  assign L_D = r_cell[13];
  assign L_E = r_cell[14];
  assign L_F = r_cell[15];

endmodule

// File: tb/tb_rx_line_buffer.sv
// Directed bench for rx_line_buffer: a scrolling instance (a_*) and a
// non-scrolling instance (b_*) share clock and reset.
module tb_rx_line_buffer;

  logic       clk;
  logic       reset;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [7:0] la [16];
  logic [7:0] lb [16];
  logic [4:0] a_count, b_count;
  logic       a_full, b_full;
  logic       a_ovr, b_ovr;

  int n_chk = 0;
  int n_err = 0;

  rx_line_buffer #(.FILL_CHAR(8'h20), .SCROLL_EN(1'b1)) u_a (
    .clk(clk), .reset(reset), .rx_data(a_data), .rx_valid(a_valid), .rx_ready(a_ready),
    .L0(la[0]), .L1(la[1]), .L2(la[2]), .L3(la[3]), .L4(la[4]), .L5(la[5]),
    .L6(la[6]), .L7(la[7]), .L8(la[8]), .L9(la[9]), .L_A(la[10]), .L_B(la[11]),
    .L_C(la[12]), .L_D(la[13]), .L_E(la[14]), .L_F(la[15]),
    .char_count(a_count), .line_full(a_full), .overrun(a_ovr)
  );

  rx_line_buffer #(.FILL_CHAR(8'h20), .SCROLL_EN(1'b0)) u_b (
    .clk(clk), .reset(reset), .rx_data(b_data), .rx_valid(b_valid), .rx_ready(b_ready),
    .L0(lb[0]), .L1(lb[1]), .L2(lb[2]), .L3(lb[3]), .L4(lb[4]), .L5(lb[5]),
    .L6(lb[6]), .L7(lb[7]), .L8(lb[8]), .L9(lb[9]), .L_A(lb[10]), .L_B(lb[11]),
    .L_C(lb[12]), .L_D(lb[13]), .L_E(lb[14]), .L_F(lb[15]),
    .char_count(b_count), .line_full(b_full), .overrun(b_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte for one cycle; returns at the negedge after the accepting posedge.
  task automatic send_a(input logic [7:0] b);
    @(negedge clk);
    a_data = b; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    @(negedge clk);
    b_data = b; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic chk_blank_a(input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s_L%0d", tag, i), la[i], 32'h20);
  endtask

  initial begin
    int lows;
    int ovrs;
    int ovr_seen;
    a_data = 8'h00; a_valid = 1'b0;
    b_data = 8'h00; b_valid = 1'b0;
    reset = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_blank_a("rst");
    chk("rst_count", a_count, 0);
    chk("rst_full", a_full, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_ovr", a_ovr, 0);
    reset = 1'b1;

    // Two printable bytes
    send_a(8'h52);
    chk("wr_count1", a_count, 1);
    send_a(8'h53);
    chk("wr_L0", la[0], 32'h52);
    chk("wr_L1", la[1], 32'h53);
    for (int i = 2; i < 16; i++) chk($sformatf("wr_L%0d", i), la[i], 32'h20);
    chk("wr_count2", a_count, 2);
    chk("wr_ovr", a_ovr, 0);

    // Erase back to empty, then backspace at zero is a no-op
    send_a(8'h08);
    send_a(8'h7F);
    chk("bs_empty_count", a_count, 0);
    chk("bs_empty_L0", la[0], 32'h20);
    send_a(8'h7F);
    chk("bs0_count", a_count, 0);
    chk("bs0_ovr", a_ovr, 0);
    chk("bs0_L0", la[0], 32'h20);

    // "ABC" then backspace
    send_a(8'h41); send_a(8'h42); send_a(8'h43);
    chk("abc_count", a_count, 3);
    send_a(8'h08);
    chk("bs_L2", la[2], 32'h20);
    chk("bs_L1", la[1], 32'h42);
    chk("bs_count", a_count, 2);
    send_a(8'h08); send_a(8'h08);
    chk("bs_clr_count", a_count, 0);

    // Ignored control and high bytes
    send_a(8'h0A);
    chk("ign0A_count", a_count, 0);
    chk("ign0A_ovr", a_ovr, 0);
    send_a(8'h80);
    chk("ign80_count", a_count, 0);
    chk("ign80_L0", la[0], 32'h20);

    // Scroll: 'A'..'Q'
    ovr_seen = 0;
    for (int i = 0; i < 17; i++) begin
      send_a(8'h41 + 8'(i));
      if (a_ovr) ovr_seen++;
      if (i == 15) chk("full_at16", a_full, 1);
    end
    chk("scr_L0", la[0], 32'h42);
    chk("scr_L1", la[1], 32'h43);
    chk("scr_LE", la[14], 32'h50);
    chk("scr_LF", la[15], 32'h51);
    chk("scr_count", a_count, 16);
    chk("scr_full", a_full, 1);
    chk("scr_no_ovr", ovr_seen, 0);

    // CR, then a byte offered 3 cycles later while busy
    @(negedge clk);
    a_data = 8'h0D; a_valid = 1'b1;
    lows = 0; ovrs = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!a_ready) lows++;
      if (a_ovr) ovrs++;
      if (i == 1) begin
        a_valid = 1'b0;
        chk("cr_count0", a_count, 0);
        chk("cr_full0", a_full, 0);
      end
      if (i == 3) begin a_data = 8'h58; a_valid = 1'b1; end
      if (i == 4) a_valid = 1'b0;
      if (i == 16) chk("cr_ready_n16", a_ready, 0);
      if (i == 17) chk("cr_ready_n17", a_ready, 1);
    end
    chk("cr_low_cycles", lows, 16);
    chk("cr_ovr_pulses", ovrs, 1);
    chk_blank_a("cr");
    chk("cr_count", a_count, 0);

    // Reset in the middle of a clear
    send_a(8'h4D); send_a(8'h4E);
    send_a(8'h0D);
    repeat (4) @(negedge clk);
    chk("mid_ready_busy", a_ready, 0);
    reset = 1'b0;
    #1;
    chk("mid_ready_rst", a_ready, 1);
    chk("mid_L1_rst", la[1], 32'h20);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_ready_rel", a_ready, 1);
    send_a(8'h54);
    chk("mid_L0_after", la[0], 32'h54);
    chk("mid_count_after", a_count, 1);

    // Non-scrolling instance: fill, overflow, ignored byte
    for (int i = 0; i < 16; i++) send_b(8'h61 + 8'(i));
    chk("ns_full", b_full, 1);
    chk("ns_count", b_count, 16);
    chk("ns_LF_fill", lb[15], 32'h70);
    send_b(8'h5A);
    chk("ns_ovr_pulse", b_ovr, 1);
    chk("ns_LF_keep", lb[15], 32'h70);
    chk("ns_L0_keep", lb[0], 32'h61);
    @(negedge clk);
    chk("ns_ovr_clear", b_ovr, 0);
    send_b(8'h0A);
    chk("ns_0A_ovr", b_ovr, 0);
    chk("ns_0A_count", b_count, 16);
    chk("ns_0A_LF", lb[15], 32'h70);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_line_buffer.md
RX_LINE_BUFFER -- requirements
Module: rx_line_buffer

Interface
REQ-001 The block SHALL have parameter FILL_CHAR, default 8'h20, the character written to blank cells.
REQ-002 The block SHALL have parameter SCROLL_EN, default 1; 1 scrolls the line when full, 0 drops characters when full.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rx_data, input, 8 bits: the received UART byte.
REQ-006 The block SHALL have port rx_valid, input, 1 bit: one-cycle strobe marking rx_data valid.
REQ-007 The block SHALL have port rx_ready, output, 1 bit: high when a byte can be accepted; combinational, high exactly in IDLE.
REQ-008 The block SHALL have ports L0..L9, L_A..L_F, each output, 8 bits: display cells 0..15, left to right, registered.
REQ-009 The block SHALL have port char_count, output, 5 bits: number of written cells, 0..16.
REQ-010 The block SHALL have port line_full, output, 1 bit: high when char_count == 16.
REQ-011 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a byte is dropped.

Function
REQ-012 A byte SHALL be accepted only on a rising edge where rx_valid && rx_ready; all resulting updates SHALL be visible the following cycle (latency 1).
REQ-013 An accepted printable byte (0x20..0x7E) with char_count < 16 SHALL be written to cell[char_count], and char_count SHALL increment.
REQ-014 An accepted printable byte with char_count == 16 and SCROLL_EN=1 SHALL shift cell[i] <= cell[i+1] for i = 0..14, with cell[15] <= byte; char_count SHALL stay 16.
REQ-015 An accepted printable byte with char_count == 16 and SCROLL_EN=0 SHALL be dropped: overrun pulses and the cells are unchanged.
REQ-016 An accepted 0x08 or 0x7F (backspace) with char_count > 0 SHALL set cell[char_count-1] <= FILL_CHAR and decrement char_count; at char_count 0 it SHALL have no effect and SHALL NOT pulse overrun.
REQ-017 An accepted 0x0D (CR) SHALL set char_count <= 0 and enter state CLEAR.
REQ-018 All other accepted bytes (0x00..0x1F except 0x08/0x0D, 0x80..0xFF) SHALL be ignored silently.
REQ-019 The FSM SHALL have states IDLE and CLEAR. In CLEAR, a 4-bit index 0..15 SHALL write FILL_CHAR to one cell per cycle; after index 15 the FSM SHALL return to IDLE.
REQ-020 rx_ready SHALL be low for exactly 16 cycles per CR.
REQ-021 rx_valid asserted while rx_ready is low SHALL drop the byte and pulse overrun for one cycle.
REQ-022 Cells SHALL only ever hold 0x20..0x7E or FILL_CHAR, so bit 7 is 0 whenever FILL_CHAR[7] is 0.
REQ-023 line_full SHALL be derived from char_count and SHALL be consistent with it on every cycle.

Reset
REQ-024 On reset low, asynchronously: all cells SHALL be set to FILL_CHAR, char_count to 0, overrun to 0, the FSM to IDLE, and the CLEAR index to 0.
REQ-025 Reset asserted mid-CLEAR SHALL abort the clear; after release the block SHALL be in IDLE with rx_ready = 1.

Verification
REQ-026 Reset scenario: assert reset -> all L = 0x20, char_count = 0, line_full = 0, rx_ready = 1, overrun = 0.
REQ-027 Write scenario: send "R" (0x52) then "S" (0x53) -> L0 = 0x52, L1 = 0x53, L2..L_F = 0x20, char_count = 2.
REQ-028 Scroll scenario (SCROLL_EN=1): send 'A'..'Q' (17 bytes) -> L0 = 'B', L_F = 'Q', char_count = 16, line_full = 1, no overrun.
REQ-029 Backspace scenario: with "ABC" written, send 0x08 -> L2 = 0x20, char_count = 2; from count 0, send 0x7F -> no change and no overrun.
REQ-030 CR scenario: send 0x0D, then a byte 3 cycles later -> rx_ready low exactly 16 cycles, the byte is dropped, overrun pulses once, and afterwards all L = 0x20 and char_count = 0.
REQ-031 No-scroll scenario (SCROLL_EN=0): fill 16 cells, send 'Z' -> overrun pulses once and L_F is unchanged; send 0x0A -> ignored with no overrun.
